// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first.
// One full-subtractor cell plus a registered borrow; valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;      // operands shift right so bit i is always at [0]
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;      // result bits enter at the MSB
  logic             a_msb;     // operand sign bits kept for the overflow test
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] d_sh_next;

  // Full-subtractor cell on the current bit and the next diff shift value
  always_comb begin
    d_bit                = a_sh[0] ^ b_sh[0] ^ br;
    br_next              = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    d_sh_next            = d_sh >> 1;
    d_sh_next[WIDTH-1]   = d_bit;
    last_bit             = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d_sh <= d_sh_next;
          br   <= br_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            // d_sh_next now holds the complete result
            diff  <= d_sh_next;
            bout  <= br_next;
            ovf   <= (a_msb ^ b_msb) & (d_sh_next[WIDTH-1] ^ a_msb);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status flags decode straight from the state register
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=1, 8 and 32 instances side by side,
// directed literal cases on the 8-bit instance, then random traffic on all.
module tb_serial_subtractor;

  typedef struct {
    longint d;
    bit     bo;
    bit     ov;
  } res_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       iv    = '0;
  logic [2:0]       ordy  = '1;
  logic [2:0]       bin_v = '0;
  logic [2:0][31:0] a_v   = '0;
  logic [2:0][31:0] b_v   = '0;
  logic [2:0][31:0] diff_v;
  logic [2:0]       ir_v, ov_v, bs_v, bo_v, ovf_v;
  int               pend [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic res_t model(input int w, input longint a, input longint b, input bit bi);
    res_t   r;
    longint full, half, ua, ub, sa, sb, s;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    ua   = a & (full - 1);
    ub   = b & (full - 1);
    r.d  = (ua - ub - longint'(bi)) & (full - 1);
    r.bo = ua < (ub + longint'(bi));
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    s    = sa - sb - longint'(bi);
    r.ov = (s < -half) || (s >= half);
    return r;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
    logic [W-1:0] diff_w;
    res_t   q[$];
    int     busy_n   = 0;
    bit     prev_ov  = 0;
    bit     exp_idle = 0;
    longint last_d   = 0;
    bit     last_bo  = 0;
    bit     last_ov  = 0;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[gi]), .in_ready(ir_v[gi]),
      .a(a_v[gi][W-1:0]), .b(b_v[gi][W-1:0]), .bin(bin_v[gi]),
      .out_valid(ov_v[gi]), .out_ready(ordy[gi]),
      .diff(diff_w), .bout(bo_v[gi]), .ovf(ovf_v[gi]), .busy(bs_v[gi])
    );
    assign diff_v[gi] = 32'(diff_w);

    // Per-instance compare process, sampling mid-cycle
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        busy_n = 0; prev_ov = 0; exp_idle = 0;
        last_d = 0; last_bo = 0; last_ov = 0;
        chk(diff_v[gi] == 0 && !bo_v[gi] && !ovf_v[gi], $sformatf("w%0d_reset_out", W),
            longint'(diff_v[gi]), 0);
        chk(ir_v[gi] && !bs_v[gi] && !ov_v[gi], $sformatf("w%0d_reset_flags", W),
            {ir_v[gi], bs_v[gi], ov_v[gi]}, 3'b100);
      end else begin
        chk($countones({ir_v[gi], bs_v[gi], ov_v[gi]}) == 1, $sformatf("w%0d_onehot", W),
            {ir_v[gi], bs_v[gi], ov_v[gi]}, 0);
        if (exp_idle) begin
          chk(ir_v[gi] == 1'b1, $sformatf("w%0d_idle_after_hs", W), ir_v[gi], 1);
          exp_idle = 0;
        end
        if (bs_v[gi]) busy_n++;
        if (ov_v[gi]) begin
          if (q.size() == 0) begin
            chk(0, $sformatf("w%0d_unexpected_out", W), 1, 0);
          end else begin
            if (!prev_ov) chk(busy_n == W, $sformatf("w%0d_latency", W), busy_n, W);
            chk(longint'(diff_v[gi]) == q[0].d, $sformatf("w%0d_diff", W), longint'(diff_v[gi]), q[0].d);
            chk(bo_v[gi] == q[0].bo, $sformatf("w%0d_bout", W), bo_v[gi], q[0].bo);
            chk(ovf_v[gi] == q[0].ov, $sformatf("w%0d_ovf", W), ovf_v[gi], q[0].ov);
            if (ordy[gi]) begin
              last_d = q[0].d; last_bo = q[0].bo; last_ov = q[0].ov;
              void'(q.pop_front());
              exp_idle = 1;
            end
          end
        end else begin
          chk(longint'(diff_v[gi]) == last_d && bo_v[gi] == last_bo && ovf_v[gi] == last_ov,
              $sformatf("w%0d_hold", W), longint'(diff_v[gi]), last_d);
        end
        if (iv[gi] && ir_v[gi]) begin
          q.push_back(model(W, longint'(a_v[gi]), longint'(b_v[gi]), bin_v[gi]));
          busy_n = 0;
        end
        prev_ov = ov_v[gi];
      end
      pend[gi] = q.size();
    end
  end

  // One directed operation on the 8-bit instance with literal expectations
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit bi,
                      input logic [7:0] ed, input bit eb, input bit eo, input string nm);
    int n;
    @(posedge clk); #1;
    a_v[1] = {24'h0, a}; b_v[1] = {24'h0, b}; bin_v[1] = bi; iv[1] = 1'b1; ordy[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    n = 0;
    for (int t = 0; t < 200 && !ov_v[1]; t++) begin
      if (bs_v[1]) n++;
      @(posedge clk); #1;
    end
    chk(ov_v[1] == 1'b1, {nm, "_timeout"}, ov_v[1], 1);
    chk(n == 8, {nm, "_busy_cycles"}, n, 8);
    chk(diff_v[1][7:0] == ed, {nm, "_diff"}, diff_v[1][7:0], ed);
    chk(bo_v[1] == eb, {nm, "_bout"}, bo_v[1], eb);
    chk(ovf_v[1] == eo, {nm, "_ovf"}, ovf_v[1], eo);
    @(posedge clk); #1;
    chk(ir_v[1] == 1'b1 && ov_v[1] == 1'b0, {nm, "_back_idle"}, {ir_v[1], ov_v[1]}, 2'b10);
  endtask

  function automatic logic [31:0] rnd(input logic [31:0] m);
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return m;
      2:       return (m >> 1) + 32'd1;
      3:       return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  // Random operand stream with random backpressure on instance k
  task automatic rand_run(input int k, input int w, input int n);
    int          done = 0;
    int          cyc  = 0;
    int          lim;
    bit          pb   = 0;
    logic [31:0] m;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    lim = n * (w + 2) * 6 + 500;
    while (done < n && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
      ordy[k] = ($urandom_range(0, 3) != 0);
      if (iv[k] && bs_v[k] && !pb) begin
        done++;
        iv[k] = 1'b0;
      end
      pb = bs_v[k];
      if (!iv[k] && done < n && $urandom_range(0, 3) != 0) begin
        a_v[k]   = rnd(m);
        b_v[k]   = rnd(m);
        bin_v[k] = 1'($urandom_range(0, 1));
        iv[k]    = 1'b1;
      end
    end
    iv[k] = 1'b0;
    chk(done == n, $sformatf("w%0d_rand_accepted", w), done, n);
  endtask

  initial begin
    #3;
    chk(diff_v[1] == 0 && ir_v[1] && !ov_v[1] && !bs_v[1], "por_state",
        longint'(diff_v[1]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "basic");
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "under0");
    run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "under1");
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf0");
    run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf1");

    // Backpressure: hold DONE for 5 cycles while a new request waits
    @(posedge clk); #1;
    a_v[1] = 32'h33; b_v[1] = 32'h11; bin_v[1] = 1'b0; iv[1] = 1'b1; ordy[1] = 1'b0;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    for (int t = 0; t < 200 && !ov_v[1]; t++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk(ov_v[1] && !ir_v[1] && !bs_v[1], "bp_flags", {ir_v[1], bs_v[1], ov_v[1]}, 3'b001);
      chk(diff_v[1][7:0] == 8'h22, "bp_diff", diff_v[1][7:0], 8'h22);
      if (i == 0) begin
        a_v[1] = 32'h99; b_v[1] = 32'h01; iv[1] = 1'b1;
      end
      @(posedge clk); #1;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    @(posedge clk); #1;
    chk(ir_v[1] && !ov_v[1] && !bs_v[1], "bp_release", {ir_v[1], bs_v[1], ov_v[1]}, 3'b100);

    // Reset at RUN cycle 3
    @(posedge clk); #1;
    a_v[1] = 32'h12; b_v[1] = 32'h34; bin_v[1] = 1'b0; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk(bs_v[1] == 1'b1, "mid_run_busy", bs_v[1], 1);
    rst_n = 1'b0;
    #1;
    chk(diff_v[1] == 0 && !bo_v[1] && !ovf_v[1], "rst_mid_out", longint'(diff_v[1]), 0);
    chk(ir_v[1] && !bs_v[1] && !ov_v[1], "rst_mid_flags", {ir_v[1], bs_v[1], ov_v[1]}, 3'b100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "after_rst");

    fork
      rand_run(0, 1, 1000);
      rand_run(1, 8, 1000);
      rand_run(2, 32, 1000);
    join
    ordy = '1;
    repeat (50) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk(pend[k] == 0, $sformatf("drain%0d", k), pend[k], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
